// File: rtl/twall_led_driver.sv
// ============================================================================
// twall_led_driver
// ----------------------------------------------------------------------------
// One slice of the tile-wall LED column driver. Several slices daisy-chain
// sout -> sin. Serial data is shifted on every dck rise. The number of dck
// rises seen with lat high selects a command. The command runs on the first
// rise with lat low:
//   1/2/3 : latch the shift register into the R/G/B channel enables
//   4     : load the config word (cfg[0] = global output enable)
//   5     : load LED-open flags {lod_b, lod_g, lod_r} for read-back
//   6     : load status {gck_q, tsd, otp_trim} for read-back
//   7     : no operation (lat_cnt saturates here)
// Lamp-test mode is entered when sin and lat are both high and both pad
// voltage codes reach VOLT_TEST_TH. It forces all channel outputs on, and
// only reset leaves it.
//
// Ports
//   dck            in   serial clock, rising edge, the only clock
//   resb           in   synchronous active-high reset
//   sin            in   serial data in
//   lat            in   latch / command strobe
//   gck            in   grey-scale clock, sampled as data
//   otp_trim[33:0] in   OTP trim word, reported in status
//   lod_r/g/b      in   LED-open detect flags per colour (16 bits each)
//   tsd            in   thermal shutdown, gates the outputs immediately
//   sin_volt       in   signed pad-level code on sin
//   lat_volt       in   signed pad-level code on lat
//   sout           out  serial out, MSB of the shift register
//   out_r/g/b      out  channel drive enables
//   dbg_lat_cnt    out  current LAT edge count (command decoder state)
//   dbg_test_mode  out  lamp-test mode flag
//   dbg_cfg        out  config word
// ============================================================================
module twall_led_driver #(
    parameter int CHANNEL_NUM  = 48,
    parameter int VOLT_TEST_TH = 7
) (
    input  logic                   dck,
    input  logic                   resb,
    input  logic                   sin,
    input  logic                   lat,
    input  logic                   gck,
    input  logic [33:0]            otp_trim,
    input  logic [15:0]            lod_r,
    input  logic [15:0]            lod_g,
    input  logic [15:0]            lod_b,
    input  logic                   tsd,
    input  logic signed [31:0]     sin_volt,
    input  logic signed [31:0]     lat_volt,
    output logic                   sout,
    output logic [CHANNEL_NUM-1:0] out_r,
    output logic [CHANNEL_NUM-1:0] out_g,
    output logic [CHANNEL_NUM-1:0] out_b,
    output logic [2:0]             dbg_lat_cnt,
    output logic                   dbg_test_mode,
    output logic [15:0]            dbg_cfg
);

    localparam logic [2:0] CMD_IDLE        = 3'd0;
    localparam logic [2:0] CMD_LATCH_R     = 3'd1;
    localparam logic [2:0] CMD_LATCH_G     = 3'd2;
    localparam logic [2:0] CMD_LATCH_B     = 3'd3;
    localparam logic [2:0] CMD_LOAD_CFG    = 3'd4;
    localparam logic [2:0] CMD_LOAD_LOD    = 3'd5;
    localparam logic [2:0] CMD_LOAD_STATUS = 3'd6;
    localparam logic [2:0] CMD_NOP         = 3'd7;

    logic [CHANNEL_NUM-1:0] r_sreg;
    logic [CHANNEL_NUM-1:0] r_latch_r;
    logic [CHANNEL_NUM-1:0] r_latch_g;
    logic [CHANNEL_NUM-1:0] r_latch_b;
    logic [15:0]            r_cfg;
    logic [2:0]             r_lat_cnt;
    logic                   r_gck_q;
    logic                   r_test_mode;

    logic                   w_sin;
    logic                   w_cmd_valid;
    logic                   w_test_entry;
    logic                   w_out_en;
    logic [47:0]            w_lod_all;
    logic [35:0]            w_status_all;
    logic [CHANNEL_NUM-1:0] w_lod_fit;
    logic [CHANNEL_NUM-1:0] w_status_fit;
    logic [CHANNEL_NUM-1:0] w_sreg_next;

    // An undriven or unknown pad reads as 0 rather than spreading X.
    assign w_sin = (sin === 1'b1);

    // A command runs on the first rise with lat low after a LAT run.
    assign w_cmd_valid = ~lat && (r_lat_cnt != CMD_IDLE);

    // The voltage codes are signed, so a negative code never qualifies.
    assign w_test_entry = lat && w_sin &&
                          (sin_volt >= VOLT_TEST_TH) &&
                          (lat_volt >= VOLT_TEST_TH);

    assign w_lod_all    = {lod_b, lod_g, lod_r};
    assign w_status_all = {r_gck_q, tsd, otp_trim};

    // Fit the read-back words to the register width.
    // The MSB end is zero-padded or truncated.
    always_comb begin
        w_lod_fit    = '0;
        w_status_fit = '0;
        for (int i = 0; (i < 48) && (i < CHANNEL_NUM); i++) begin
            w_lod_fit[i] = w_lod_all[i];
        end
        for (int i = 0; (i < 36) && (i < CHANNEL_NUM); i++) begin
            w_status_fit[i] = w_status_all[i];
        end
    end

    // A status load replaces the shift on that edge.
    always_comb begin
        w_sreg_next = {r_sreg[CHANNEL_NUM-2:0], w_sin};
        if (w_cmd_valid && (r_lat_cnt == CMD_LOAD_LOD)) begin
            w_sreg_next = w_lod_fit;
        end else if (w_cmd_valid && (r_lat_cnt == CMD_LOAD_STATUS)) begin
            w_sreg_next = w_status_fit;
        end
    end

    always_ff @(posedge dck) begin
        if (resb) begin
            r_sreg      <= '0;
            r_latch_r   <= '0;
            r_latch_g   <= '0;
            r_latch_b   <= '0;
            r_cfg       <= '0;
            r_lat_cnt   <= CMD_IDLE;
            r_gck_q     <= 1'b0;
            r_test_mode <= 1'b0;
        end else begin
            r_sreg  <= w_sreg_next;
            r_gck_q <= gck;

            if (lat) begin
                if (r_lat_cnt != CMD_NOP) begin
                    r_lat_cnt <= r_lat_cnt + 3'd1;
                end
            end else begin
                r_lat_cnt <= CMD_IDLE;
            end

            // Decode uses the pre-edge shift register contents.
            if (w_cmd_valid) begin
                case (r_lat_cnt)
                    CMD_LATCH_R:  r_latch_r <= r_sreg;
                    CMD_LATCH_G:  r_latch_g <= r_sreg;
                    CMD_LATCH_B:  r_latch_b <= r_sreg;
                    CMD_LOAD_CFG: r_cfg     <= r_sreg[15:0];
                    default:      ;
                endcase
            end

            if (w_test_entry) begin
                r_test_mode <= 1'b1;
            end
        end
    end

    // tsd gates the outputs directly and leaves the latches unchanged.
    assign w_out_en = r_cfg[0] & ~tsd;

    assign out_r = r_test_mode ? {CHANNEL_NUM{1'b1}} : (r_latch_r & {CHANNEL_NUM{w_out_en}});
    assign out_g = r_test_mode ? {CHANNEL_NUM{1'b1}} : (r_latch_g & {CHANNEL_NUM{w_out_en}});
    assign out_b = r_test_mode ? {CHANNEL_NUM{1'b1}} : (r_latch_b & {CHANNEL_NUM{w_out_en}});

    assign sout          = r_sreg[CHANNEL_NUM-1];
    assign dbg_lat_cnt   = r_lat_cnt;
    assign dbg_test_mode = r_test_mode;
    assign dbg_cfg       = r_cfg;

endmodule

// File: tb/tb_twall_led_driver.sv
// ============================================================================
// tb_twall_led_driver
// ----------------------------------------------------------------------------
// Two twall_led_driver slices in a chain: u_dut0.sout -> u_dut1.sin.
// The driver sets the inputs just after each dck rise and queues the
// hand-computed values it expects. The monitor pops and compares every
// queued value at the next dck fall.
// ============================================================================
module tb_twall_led_driver;

    localparam int CH = 48;

    localparam int S_OUT_R0 = 0;
    localparam int S_OUT_G0 = 1;
    localparam int S_OUT_B0 = 2;
    localparam int S_SOUT0  = 3;
    localparam int S_TM0    = 4;
    localparam int S_OUT_R1 = 5;
    localparam int S_LATC0  = 6;
    localparam int S_CFG0   = 7;

    logic               dck;
    logic               resb;
    logic               sin;
    logic               lat;
    logic               gck;
    logic [33:0]        otp_trim;
    logic [15:0]        lod_r;
    logic [15:0]        lod_g;
    logic [15:0]        lod_b;
    logic               tsd;
    logic signed [31:0] sin_volt;
    logic signed [31:0] lat_volt;

    logic               sout0;
    logic               sout1;
    logic [CH-1:0]      out_r0, out_g0, out_b0;
    logic [CH-1:0]      out_r1, out_g1, out_b1;
    logic [2:0]         latc0, latc1;
    logic               tm0, tm1;
    logic [15:0]        cfg0, cfg1;

    logic [CH-1:0]      exp_q[$];
    int                 sel_q[$];
    int                 n_cmp;
    int                 n_mis;

    logic [47:0]        mon_e;
    logic [47:0]        mon_a;
    int                 mon_s;

    // Bench-side reference words.
    logic [47:0]        d_a5;
    logic [47:0]        d_g;
    logic [47:0]        d_ch_a;
    logic [47:0]        d_ch_b;
    logic [47:0]        s_word;

    twall_led_driver #(.CHANNEL_NUM(CH), .VOLT_TEST_TH(7)) u_dut0 (
        .dck(dck), .resb(resb), .sin(sin), .lat(lat), .gck(gck),
        .otp_trim(otp_trim), .lod_r(lod_r), .lod_g(lod_g), .lod_b(lod_b),
        .tsd(tsd), .sin_volt(sin_volt), .lat_volt(lat_volt),
        .sout(sout0), .out_r(out_r0), .out_g(out_g0), .out_b(out_b0),
        .dbg_lat_cnt(latc0), .dbg_test_mode(tm0), .dbg_cfg(cfg0)
    );

    twall_led_driver #(.CHANNEL_NUM(CH), .VOLT_TEST_TH(7)) u_dut1 (
        .dck(dck), .resb(resb), .sin(sout0), .lat(lat), .gck(gck),
        .otp_trim(otp_trim), .lod_r(lod_r), .lod_g(lod_g), .lod_b(lod_b),
        .tsd(tsd), .sin_volt(sin_volt), .lat_volt(lat_volt),
        .sout(sout1), .out_r(out_r1), .out_g(out_g1), .out_b(out_b1),
        .dbg_lat_cnt(latc1), .dbg_test_mode(tm1), .dbg_cfg(cfg1)
    );

    // ---------------- clock ----------------
    initial begin
        dck = 1'b0;
        forever #5 dck = ~dck;
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [47:0] actual(input int s);
        case (s)
            S_OUT_R0: return out_r0;
            S_OUT_G0: return out_g0;
            S_OUT_B0: return out_b0;
            S_SOUT0:  return {47'd0, sout0};
            S_TM0:    return {47'd0, tm0};
            S_OUT_R1: return out_r1;
            S_LATC0:  return {45'd0, latc0};
            S_CFG0:   return {32'd0, cfg0};
            default:  return '0;
        endcase
    endfunction

    function automatic string sel_name(input int s);
        case (s)
            S_OUT_R0: return "out_r0";
            S_OUT_G0: return "out_g0";
            S_OUT_B0: return "out_b0";
            S_SOUT0:  return "sout0";
            S_TM0:    return "test_mode0";
            S_OUT_R1: return "out_r1";
            S_LATC0:  return "lat_cnt0";
            S_CFG0:   return "cfg0";
            default:  return "unknown";
        endcase
    endfunction

    task automatic push_exp(input int s, input logic [47:0] v);
        sel_q.push_back(s);
        exp_q.push_back(v);
    endtask

    // ---------------- monitor ----------------
    always @(negedge dck) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_s = sel_q.pop_front();
            mon_a = actual(mon_s);
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_mis++;
                $display("FAIL %s: got %h expected %h at %0t", sel_name(mon_s), mon_a, mon_e, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clk_bit(input logic s, input logic l);
        sin = s;
        lat = l;
        @(posedge dck);
        #1;
    endtask

    // Wait until the monitor has consumed the pending checks.
    task automatic settle();
        @(negedge dck);
        #1;
    endtask

    // 96 bits MSB-first. u_dut1 ends up holding hi and u_dut0 holds lo.
    // lat is high on the last ncmd bits, followed by one trailing lat-low dck.
    task automatic frame(input logic [47:0] hi, input logic [47:0] lo, input int ncmd);
        logic [95:0] d;
        d = {hi, lo};
        for (int i = 95; i >= 0; i--) begin
            clk_bit(d[i], (i < ncmd));
        end
        clk_bit(1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        resb     = 1'b1;
        sin      = 1'b0;
        lat      = 1'b0;
        gck      = 1'b0;
        otp_trim = '0;
        lod_r    = '0;
        lod_g    = '0;
        lod_b    = '0;
        tsd      = 1'b0;
        sin_volt = 32'sd5;
        lat_volt = 32'sd5;
        d_a5     = 48'hA5A5_0000_FFFF;
        d_g      = 48'h1234_5678_9ABC;
        d_ch_a   = 48'hF0F0_1234_5678;
        d_ch_b   = 48'h0F0F_ABCD_EF01;

        // Reset for two dck.
        clk_bit(1'b0, 1'b0);
        clk_bit(1'b0, 1'b0);
        push_exp(S_SOUT0,  48'd0);
        push_exp(S_OUT_R0, 48'd0);
        push_exp(S_OUT_G0, 48'd0);
        push_exp(S_OUT_B0, 48'd0);
        push_exp(S_TM0,    48'd0);
        push_exp(S_LATC0,  48'd0);
        settle();
        resb = 1'b0;

        // Latch R, then enable the outputs through cfg.
        frame(d_a5, d_a5, 1);
        push_exp(S_OUT_R0, 48'd0);          // cfg still off
        frame(48'd1, 48'd1, 4);
        push_exp(S_CFG0,   48'd1);
        push_exp(S_OUT_R0, d_a5);
        push_exp(S_OUT_G0, 48'd0);
        push_exp(S_OUT_B0, 48'd0);
        settle();

        // Latch B, then G, then gate everything with tsd.
        frame(d_a5, d_a5, 3);
        push_exp(S_OUT_B0, d_a5);
        push_exp(S_OUT_R0, d_a5);
        push_exp(S_OUT_G0, 48'd0);
        frame(d_g, d_g, 2);
        push_exp(S_OUT_G0, d_g);
        settle();
        tsd = 1'b1;
        push_exp(S_OUT_B0, 48'd0);
        push_exp(S_OUT_R0, 48'd0);
        settle();
        tsd = 1'b0;
        push_exp(S_OUT_B0, d_a5);
        push_exp(S_OUT_G0, d_g);
        settle();

        // A LAT pulse with no dck in it does nothing.
        lat = 1'b1;
        #1;
        lat = 1'b0;
        clk_bit(1'b0, 1'b0);
        push_exp(S_LATC0,  48'd0);
        push_exp(S_OUT_R0, d_a5);
        push_exp(S_OUT_G0, d_g);
        settle();

        // LED-open read-back: bit 47 first, bit 0 last.
        lod_r  = 16'h0001;
        lod_g  = 16'h0F00;
        lod_b  = 16'h8000;
        s_word = 48'h8000_0F00_0001;
        frame(48'd0, 48'd0, 5);
        for (int k = 47; k >= 0; k--) begin
            push_exp(S_SOUT0, {47'd0, s_word[k]});
            settle();
            if (k > 0) clk_bit(1'b0, 1'b0);
        end
        push_exp(S_OUT_R0, d_a5);
        settle();

        // Status read-back: gck_q=1, tsd=0, otp 34'h2_DEAD_BEEF.
        gck      = 1'b1;
        otp_trim = 34'h2_DEAD_BEEF;
        s_word   = 48'h000A_DEAD_BEEF;
        frame(48'd0, 48'd0, 6);
        for (int k = 47; k >= 0; k--) begin
            push_exp(S_SOUT0, {47'd0, s_word[k]});
            settle();
            if (k > 0) clk_bit(1'b0, 1'b0);
        end

        // Chain: the far chip (u_dut1) keeps the first 48 bits sent.
        frame(d_ch_a, d_ch_b, 1);
        push_exp(S_OUT_R1, d_ch_a);
        push_exp(S_OUT_R0, d_ch_b);
        settle();

        // Test-mode qualification misses, held in one long LAT run.
        sin_volt = 32'sd5;          lat_volt = 32'sd5;          clk_bit(1'b1, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sd6;          lat_volt = 32'sd7;          clk_bit(1'b1, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sd7;          lat_volt = 32'sd6;          clk_bit(1'b1, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sh8000_0000;  lat_volt = 32'sd7;          clk_bit(1'b1, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sd7;          lat_volt = 32'sh8000_0000;  clk_bit(1'b1, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sd7;          lat_volt = 32'sd7;          clk_bit(1'b0, 1'b1);
        push_exp(S_TM0, 48'd0);
        sin_volt = 32'sd5;          lat_volt = 32'sd5;
        clk_bit(1'b1, 1'b1);
        clk_bit(1'b1, 1'b1);
        push_exp(S_LATC0, 48'd7);           // saturated after 8 edges
        settle();
        clk_bit(1'b0, 1'b0);                // lat_cnt 7 -> no operation
        push_exp(S_LATC0,  48'd0);
        push_exp(S_OUT_R0, d_ch_b);
        push_exp(S_OUT_G0, d_g);
        push_exp(S_OUT_B0, d_a5);
        settle();

        // Test-mode entry forces lamp test over tsd.
        sin_volt = 32'sd7;
        lat_volt = 32'sd7;
        clk_bit(1'b1, 1'b1);
        push_exp(S_TM0,    48'd1);
        push_exp(S_OUT_R0, {48{1'b1}});
        push_exp(S_OUT_G0, {48{1'b1}});
        push_exp(S_OUT_B0, {48{1'b1}});
        settle();
        sin_volt = 32'sd5;
        lat_volt = 32'sd5;
        clk_bit(1'b0, 1'b0);
        tsd = 1'b1;
        push_exp(S_TM0,    48'd1);
        push_exp(S_OUT_G0, {48{1'b1}});
        settle();
        tsd = 1'b0;

        // Only reset leaves test mode.
        resb = 1'b1;
        clk_bit(1'b0, 1'b0);
        push_exp(S_TM0,    48'd0);
        push_exp(S_OUT_R0, 48'd0);
        push_exp(S_CFG0,   48'd0);
        settle();
        resb = 1'b0;

        // Reset in the middle of a LAT run aborts the pending command.
        clk_bit(1'b1, 1'b1);
        clk_bit(1'b1, 1'b1);
        push_exp(S_LATC0, 48'd2);
        settle();
        resb = 1'b1;
        clk_bit(1'b0, 1'b1);
        push_exp(S_LATC0, 48'd0);
        settle();
        resb = 1'b0;
        clk_bit(1'b0, 1'b0);
        push_exp(S_LATC0,  48'd0);
        push_exp(S_OUT_G0, 48'd0);
        settle();

        // Bounded drain of anything still queued.
        for (int g = 0; (g < 20) && (exp_q.size() > 0); g++) begin
            @(negedge dck);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d checks left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        n_cmp++;
        n_mis++;
        $display("FAIL watchdog: time limit reached, required end of stimulus");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
